// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the memory responder.
// I/O register offsets, STATUS bit positions, loader states.
package mem_responder_pkg;

  localparam int DATA_W = 16;

  localparam logic [15:0] IO_STATUS   = 16'd0;
  localparam logic [15:0] IO_CYCLE_LO = 16'd1;
  localparam logic [15:0] IO_CYCLE_HI = 16'd2;
  localparam logic [15:0] IO_OUT      = 16'd3;

  localparam int ST_VALID_BIT = 0;
  localparam int ST_OVF_BIT   = 1;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LO,
    LD_HI,
    LD_RELEASE
  } ld_state_e;

endpackage

// File: rtl/mem_responder_loader_fsm.sv
// Byte-stream program loader: assembles 16-bit words from byte pairs,
// walks the load address and holds the CPU in reset around a session.
module mem_responder_loader_fsm #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int RELEASE_DLY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_busy,
  output logic              cpu_reset,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  import mem_responder_pkg::*;

  localparam int CNT_W = $clog2(RELEASE_DLY + 1);
  localparam logic [CNT_W-1:0] DLY = CNT_W'(RELEASE_DLY);

  ld_state_e state_q;
  ld_state_e state_d;

  logic              en_q;
  logic              rise;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              enter_rel;
  logic              cnt_run;

  assign rise = ld_en & ~en_q;

  assign enter_rel = ((state_q == LD_LO) || (state_q == LD_HI)) && !ld_en;

  // The release counter also holds the CPU after a hard reset,
  // but only counts down once ld_en is low.
  assign cnt_run = (cnt_q != '0) &&
                   (((state_q == LD_RELEASE) && !rise) ||
                    ((state_q == LD_IDLE) && !ld_en));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= LD_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a dropped ld_en wins over a pending byte
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE: begin
        if (rise) state_d = LD_LO;
      end
      LD_LO: begin
        if (!ld_en)        state_d = LD_RELEASE;
        else if (ld_valid) state_d = LD_HI;
      end
      LD_HI: begin
        if (!ld_en)        state_d = LD_RELEASE;
        else if (ld_valid) state_d = LD_LO;
      end
      LD_RELEASE: begin
        if (rise)                      state_d = LD_LO;
        else if (cnt_q <= CNT_W'(1))   state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Edge detect, load address, low byte latch and release counter;
  // en_q tracks ld_en through reset so a held ld_en is not a new session
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= ld_en;
      addr_q <= '0;
      lo_q   <= '0;
      cnt_q  <= DLY;
    end else begin
      en_q <= ld_en;
      if (rise)       addr_q <= '0;
      else if (wr_en) addr_q <= addr_q + ADDR_W'(1);
      if ((state_q == LD_LO) && ld_en && ld_valid) lo_q <= ld_byte;
      if (enter_rel)    cnt_q <= DLY;
      else if (cnt_run) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Outputs: write port toward RAM and the CPU hold
  always_comb begin
    ld_busy   = (state_q != LD_IDLE);
    cpu_reset = reset | (state_q != LD_IDLE) | (cnt_q != '0);
    wr_en     = (state_q == LD_HI) & ld_en & ld_valid;
    wr_addr   = addr_q;
    wr_data   = DATA_W'({ld_byte, lo_q});
  end

endmodule

// File: rtl/mem_responder.sv
// Responder for the CPU fetch port (A) and data port (B) with an
// I/O window holding STATUS, a cycle counter and an output channel.
module mem_responder #(
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 16,
  parameter logic [15:0] IO_BASE     = 16'hFF00,
  parameter int          RELEASE_DLY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic [15:0]       addr_b,
  input  logic [DATA_W-1:0] din_b,
  input  logic              we_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              cpu_reset,
  input  logic              ld_en,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  import mem_responder_pkg::*;

  localparam int RAM_WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [31:0]       cycle_cnt;
  logic              overflow;

  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic              cpu_we;
  logic              is_ram;
  logic              sel_status;
  logic              sel_lo;
  logic              sel_hi;
  logic              sel_out;
  logic              out_wr;
  logic              out_take;
  logic              out_fire;
  logic [DATA_W-1:0] status_w;

  mem_responder_loader_fsm #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RELEASE_DLY (RELEASE_DLY)
  ) u_loader (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (ld_en),
    .ld_byte   (ld_byte),
    .ld_valid  (ld_valid),
    .ld_busy   (ld_busy),
    .cpu_reset (cpu_reset),
    .wr_en     (ld_wr),
    .wr_addr   (ld_addr),
    .wr_data   (ld_data)
  );

  // The CPU's we_b is not reset, so gate it with our own hold
  assign cpu_we     = we_b & ~cpu_reset;
  assign is_ram     = 32'(addr_b) < 32'(RAM_WORDS);
  assign sel_status = (addr_b == IO_BASE + IO_STATUS);
  assign sel_lo     = (addr_b == IO_BASE + IO_CYCLE_LO);
  assign sel_hi     = (addr_b == IO_BASE + IO_CYCLE_HI);
  assign sel_out    = (addr_b == IO_BASE + IO_OUT);
  assign out_wr     = cpu_we & sel_out;
  assign out_fire   = out_valid & out_ready;
  assign out_take   = out_wr & (~out_valid | out_ready);

  // RAM write port; the loader has priority over the CPU
  always_ff @(posedge clk) begin
    if (ld_wr)                 ram[ld_addr] <= ld_data;
    else if (cpu_we && is_ram) ram[addr_b[ADDR_W-1:0]] <= din_b;
  end

  // Fetch port: registered read, old data on a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) dout_a <= '0;
    else       dout_a <= ram[addr_a];
  end

  // Output channel register and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (out_take) begin
        out_data  <= din_b;
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_wr && out_valid && !out_ready)
        overflow <= 1'b1;
      else if (cpu_we && sel_status && din_b[ST_OVF_BIT])
        overflow <= 1'b0;
    end
  end

  // Free-running 32-bit cycle counter
  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  // STATUS word assembly
  always_comb begin
    status_w               = '0;
    status_w[ST_VALID_BIT] = out_valid;
    status_w[ST_OVF_BIT]   = overflow;
  end

  // Port B read mux, no side effects
  always_comb begin
    dout_b = '0;
    unique case (1'b1)
      is_ram:     dout_b = ram[addr_b[ADDR_W-1:0]];
      sel_status: dout_b = status_w;
      sel_lo:     dout_b = DATA_W'(cycle_cnt[15:0]);
      sel_hi:     dout_b = DATA_W'(cycle_cnt[31:16]);
      sel_out:    dout_b = out_data;
      default:    dout_b = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed loader/port scenarios plus random
// port-B traffic against a behavioural model with an output scoreboard.
module tb_mem_responder;

  localparam logic [15:0] IOB = 16'hFF00;

  logic        clk;
  logic        reset;
  logic [11:0] addr_a;
  logic [15:0] dout_a;
  logic [15:0] addr_b;
  logic [15:0] din_b;
  logic        we_b;
  logic [15:0] dout_b;
  logic        cpu_reset;
  logic        ld_en;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_busy;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .addr_a    (addr_a),
    .dout_a    (dout_a),
    .addr_b    (addr_b),
    .din_b     (din_b),
    .we_b      (we_b),
    .dout_b    (dout_b),
    .cpu_reset (cpu_reset),
    .ld_en     (ld_en),
    .ld_byte   (ld_byte),
    .ld_valid  (ld_valid),
    .ld_busy   (ld_busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mram [4096];
  bit          m_full;
  bit          m_ovf;
  logic [15:0] m_od;
  logic [31:0] m_cyc;
  logic [15:0] expq [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a < 16'h1000) return mram[a[11:0]];
    if (a == IOB)          return {14'b0, m_ovf, m_full};
    if (a == IOB + 16'd1)  return m_cyc[15:0];
    if (a == IOB + 16'd2)  return m_cyc[31:16];
    if (a == IOB + 16'd3)  return m_od;
    return 16'h0000;
  endfunction

  task automatic m_update(input logic [15:0] a, input logic [15:0] d,
                          input bit we, input bit rdy);
    bit is_out;
    bit was_full;
    is_out   = we && (a == IOB + 16'd3);
    was_full = m_full;
    if (we && a < 16'h1000) mram[a[11:0]] = d;
    if (is_out && (!was_full || rdy)) begin
      m_full = 1'b1;
      m_od   = d;
      expq.push_back(d);
    end else if (was_full && rdy) begin
      m_full = 1'b0;
    end
    if (is_out && was_full && !rdy) m_ovf = 1'b1;
    else if (we && a == IOB && d[1]) m_ovf = 1'b0;
  endtask

  task automatic m_reset();
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_od   = 16'h0000;
    expq.delete();
  endtask

  // Cycle count since reset, from plain counting
  initial begin
    m_cyc = 32'd0;
    forever begin
      @(posedge clk);
      if (reset) m_cyc = 32'd0;
      else       m_cyc = m_cyc + 32'd1;
    end
  end

  // Output monitor: a transfer happens at the next edge when valid&ready
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got %h expected none", out_data);
        end else begin
          e = expq.pop_front();
          chk("out_transfer", 32'(out_data), 32'(e));
        end
      end
    end
  end

  // One CPU bus cycle on both ports, checked against the model
  task automatic cycle(input logic [15:0] a, input logic [15:0] d,
                       input bit we, input bit rdy, input logic [11:0] aa,
                       output logic [15:0] rb);
    logic [15:0] ea;
    @(negedge clk);
    addr_b    = a;
    din_b     = d;
    we_b      = we;
    out_ready = rdy;
    addr_a    = aa;
    #1;
    rb = dout_b;
    chk("port_b_read", 32'(dout_b), 32'(m_read(a)));
    ea = mram[aa];
    @(posedge clk);
    m_update(a, d, we, rdy);
    #1;
    chk("port_a_read", 32'(dout_a), 32'(ea));
    we_b      = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (cpu_reset && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic load(input logic [7:0] b[$], input bit poke);
    int n;
    @(negedge clk);
    ld_en     = 1'b1;
    ld_valid  = 1'b0;
    out_ready = 1'b0;
    we_b      = 1'b0;
    foreach (b[i]) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = b[i];
      if (poke) begin
        we_b   = 1'b1;
        addr_b = 16'h0005;
        din_b  = 16'hDEAD;
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_en    = 1'b0;
    we_b     = 1'b0;
    for (int i = 0; i + 1 < b.size(); i += 2)
      mram[12'(i / 2)] = {b[i + 1], b[i]};
    @(posedge clk);
    #1;
    chk("release_hold", 32'(cpu_reset), 32'd1);
    wait_release(n);
    chk("release_dly", 32'(n), 32'd2);
    chk("ld_busy_idle", 32'(ld_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  bq [$];
    logic [15:0] rb;
    logic [15:0] a;
    int          n;
    int          r;

    reset     = 1'b1;
    addr_a    = '0;
    addr_b    = '0;
    din_b     = '0;
    we_b      = 1'b0;
    ld_en     = 1'b0;
    ld_byte   = '0;
    ld_valid  = 1'b0;
    out_ready = 1'b0;
    m_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_ld_busy", 32'(ld_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_release(n);
    chk("post_reset_release", 32'(n), 32'd2);

    bq.delete();
    for (int i = 0; i < 64; i++) bq.push_back(8'($urandom_range(0, 255)));
    load(bq, 1'b0);

    bq = {8'h34, 8'h12, 8'hCD, 8'hAB};
    load(bq, 1'b0);
    cycle(16'h0000, 16'h0, 1'b0, 1'b0, 12'd0, rb);
    chk("ram0_loaded", 32'(rb), 32'h1234);
    @(negedge clk);
    addr_a = 12'd1;
    #1;
    chk("porta_not_yet", 32'(dout_a), 32'h1234);
    cycle(16'h0001, 16'h0, 1'b0, 1'b0, 12'd1, rb);
    chk("ram1_loaded", 32'(rb), 32'hABCD);
    chk("porta_latency", 32'(dout_a), 32'hABCD);

    cycle(16'h0010, 16'h5A5A, 1'b1, 1'b0, 12'd2, rb);
    cycle(16'h0010, 16'h0, 1'b0, 1'b0, 12'd16, rb);
    chk("ram_store_load", 32'(rb), 32'h5A5A);
    cycle(16'h2000, 16'h0, 1'b0, 1'b0, 12'd3, rb);
    chk("unmapped_read", 32'(rb), 32'h0);

    cycle(IOB + 16'd3, 16'h0041, 1'b1, 1'b0, 12'd0, rb);
    cycle(IOB, 16'h0, 1'b0, 1'b0, 12'd0, rb);
    chk("status_valid", 32'(rb), 32'h0001);
    chk("out_valid_set", 32'(out_valid), 32'd1);
    cycle(IOB + 16'd3, 16'h0042, 1'b1, 1'b0, 12'd0, rb);
    cycle(IOB, 16'h0, 1'b0, 1'b0, 12'd0, rb);
    chk("status_overflow", 32'(rb), 32'h0003);
    chk("out_data_held", 32'(out_data), 32'h0041);
    cycle(IOB + 16'd3, 16'h0, 1'b0, 1'b1, 12'd0, rb);
    chk("out_reg_read", 32'(rb), 32'h0041);
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    cycle(IOB, 16'h0002, 1'b1, 1'b0, 12'd0, rb);
    cycle(IOB, 16'h0, 1'b0, 1'b0, 12'd0, rb);
    chk("status_cleared", 32'(rb), 32'h0000);

    bq = {8'h11, 8'h22, 8'h33};
    load(bq, 1'b1);
    cycle(16'h0005, 16'h0, 1'b0, 1'b0, 12'd5, rb);
    chk("masked_write_ram5", 32'(rb), 32'(mram[5]));
    cycle(16'h0000, 16'h0, 1'b0, 1'b0, 12'd1, rb);
    chk("odd_load_ram0", 32'(rb), 32'h2211);
    cycle(16'h0001, 16'h0, 1'b0, 1'b0, 12'd0, rb);
    chk("odd_load_ram1", 32'(rb), 32'hABCD);

    @(negedge clk);
    ld_en = 1'b1;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = 8'h77;
    @(negedge clk);
    ld_valid = 1'b0;
    reset    = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    chk("reset_midload_idle", 32'(ld_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("no_session_held_en", 32'(ld_busy), 32'd0);
    chk("cpu_held_en_high", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    ld_en = 1'b0;
    wait_release(n);
    chk("release_after_reset", 32'(n), 32'd2);
    cycle(16'h0000, 16'h0, 1'b0, 1'b0, 12'd0, rb);
    chk("ram_retained", 32'(rb), 32'h2211);

    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    m_cyc  = 32'hFFFF_FFFF;
    we_b   = 1'b0;
    addr_b = IOB + 16'd2;
    #1;
    chk("cycle_hi_max", 32'(dout_b), 32'hFFFF);
    addr_b = IOB + 16'd1;
    #1;
    chk("cycle_lo_max", 32'(dout_b), 32'hFFFF);
    release dut.cycle_cnt;
    @(posedge clk);
    #1;
    chk("cycle_lo_wrap", 32'(dout_b), 32'h0000);
    addr_b = IOB + 16'd2;
    #1;
    chk("cycle_hi_wrap", 32'(dout_b), 32'h0000);

    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)       a = 16'($urandom_range(0, 31));
      else if (r == 5) a = IOB;
      else if (r == 6) a = IOB + 16'($urandom_range(1, 2));
      else if (r < 9)  a = IOB + 16'd3;
      else             a = 16'h1000 + 16'($urandom_range(0, 16'hEE00));
      cycle(a, 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), rb);
    end

    repeat (4) cycle(IOB, 16'h0, 1'b0, 1'b1, 12'd0, rb);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the CPU's two memory ports.
- Port A is the instruction fetch port, read-only.
- Port B is the data port: load/store with a memory-mapped I/O window.
- Also contains a byte-stream program loader that fills RAM while holding the CPU in reset, plus an output channel and a cycle counter mapped on port B.

Parameters:
- ADDR_W, 12, RAM word-address width; RAM depth is 2**ADDR_W words.
- DATA_W, 16, word width.
- IO_BASE, 16'hFF00, base address of the I/O register window on port B.
- RELEASE_DLY, 2, cycles cpu_reset stays high after the loader finishes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- addr_a  in  ADDR_W  fetch address from CPU
- dout_a  out  DATA_W  fetch data, registered
- addr_b  in  16  data address from CPU
- din_b  in  DATA_W  store data
- we_b  in  1  store enable
- dout_b  out  DATA_W  load data, combinational
- cpu_reset  out  1  reset to CPU
- ld_en  in  1  loader session active (level)
- ld_byte  in  8  loader byte
- ld_valid  in  1  ld_byte qualifier, one byte per cycle
- ld_busy  out  1  loader FSM not IDLE
- out_data  out  DATA_W  output channel data
- out_valid  out  1  output channel valid
- out_ready  in  1  output channel consumer ready

Behaviour:
- Clock and reset: clk, reset synchronous active-high.
- Reset values:
  - dout_a = 0, out_valid = 0, out_data = 0, overflow = 0, cycle counter = 0.
  - Loader FSM goes to IDLE; ld_busy = 0.
  - cpu_reset = 1, then released after RELEASE_DLY cycles if ld_en = 0.
- Port A:
  - dout_a <= ram[addr_a] at every posedge, giving 1-cycle latency.
  - A same-cycle port-B write to the same word returns the old data.
- Port B read (combinational, no read side effects):
  - addr_b < 2**ADDR_W: ram[addr_b[ADDR_W-1:0]].
  - IO_BASE+0 STATUS: {14'b0, overflow, out_valid}.
  - IO_BASE+1 CYCLE_LO: counter[15:0].
  - IO_BASE+2 CYCLE_HI: counter[31:16].
  - IO_BASE+3 OUT: reads out_data.
  - Any other address reads 0.
- Port B write:
  - Takes effect at posedge when we_b = 1 and cpu_reset = 0.
  - Writes while cpu_reset = 1 are ignored, because the CPU's we_b is not reset.
  - RAM region: ram[addr_b] <= din_b.
  - IO_BASE+3 OUT with out_valid = 0, or with out_valid = 1 and out_ready = 1 in the same cycle: out_data <= din_b, out_valid <= 1.
  - IO_BASE+3 OUT with out_valid = 1 and out_ready = 0: data is dropped and overflow <= 1.
  - IO_BASE+0 STATUS: din_b[1] = 1 clears overflow.
  - CYCLE_LO, CYCLE_HI, unmapped addresses: writes ignored.
- Output handshake:
  - A transfer occurs at the posedge where out_valid & out_ready; out_valid then drops unless a new OUT write lands in the same cycle.
  - out_data is stable while out_valid = 1 and out_ready = 0.
- Cycle counter: 32-bit, increments every cycle, wraps 0xFFFFFFFF -> 0. The two halves are not read atomically; software re-reads CYCLE_HI.
- Loader FSM, states IDLE, LO, HI, RELEASE:
  - IDLE, ld_en rising: ld_addr <= 0, cpu_reset <= 1, go to LO.
  - LO, ld_valid: latch byte as the low half, go to HI.
  - HI, ld_valid: ram[ld_addr] <= {ld_byte, lo}, ld_addr++ (wraps at 2**ADDR_W), go to LO.
  - LO or HI, ld_en falls: go to RELEASE. A dangling low byte in HI is discarded, not written.
  - RELEASE: count RELEASE_DLY cycles, then cpu_reset <= 0 and go to IDLE.
  - ld_en rising during RELEASE: return to LO with ld_addr <= 0.
- Loader and CPU write priority: the loader write always wins; CPU writes are already masked by cpu_reset.
- cpu_reset = 1 whenever reset = 1, or the FSM is not IDLE.
- Reset mid-load: FSM goes to IDLE immediately and RAM contents are retained. If ld_en is still high after reset, a new session starts only on the next ld_en rising edge.

Decomposition:
- Shared package holds:
  - I/O register offsets: STATUS = 0, CYCLE_LO = 1, CYCLE_HI = 2, OUT = 3.
  - STATUS bit positions.
  - Loader state encoding.
  - DATA_W.
- One natural sub-module, loader_fsm: byte assembly, ld_addr, cpu_reset generation. It presents a write port (we, addr, data) to the top.

Test Plan:
- Reset then ld_en pulse with bytes 0x34, 0x12, 0xCD, 0xAB -> ram[0] = 0x1234, ram[1] = 0xABCD. cpu_reset stays high until exactly 2 cycles after ld_en falls.
- Port A: addr_a = 1 at edge N -> dout_a = 0xABCD after edge N+1, not before.
- Port B: write 0x5A5A to addr_b = 0x0010, then read 0x0010 -> dout_b = 0x5A5A in the same cycle addr_b is applied. Read 0x2000 -> 0.
- OUT writes:
  - Write 0x0041 to IO_BASE+3 with out_ready = 0 -> out_valid = 1, STATUS = 0x0001.
  - Second write 0x0042 -> out_data stays 0x0041, STATUS = 0x0003.
  - out_ready = 1 -> out_valid drops.
  - Write 0x0002 to STATUS -> STATUS = 0x0000.
- we_b = 1 with addr_b = 0x0005 while cpu_reset = 1 -> ram[5] unchanged. Odd byte count (3 bytes) -> only ram[0] written, ram[1] untouched.
- Assert reset during state HI -> ld_busy = 0 the next cycle, ram[0] retained. Cycle counter forced to 0xFFFFFFFF (via reset release plus count, or a hierarchical force) -> wraps to 0; CYCLE_HI reads 0.
